// File: rtl/xentry_pkg.sv
// Shared types for the xentry memory subsystem: memory operation kinds plus
// the L2 port arbiter's state and requester identifiers.
// Ports: none (package only).
package xentry_pkg;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } memory_operation_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } requester_e;

  // The requester that did not take the previous grant.
  function automatic requester_e other_requester(input requester_e r);
    return (r == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
  endfunction

endpackage

// File: rtl/l2_rr_picker.sv
// Combinational two-way round-robin select between icache and dcache.
// Ports: ic_valid/dc_valid request lines, last_grant history in;
//        grant_valid (any request) and grant_id (winner) out.
module l2_rr_picker
  import xentry_pkg::*;
(
  input  logic       ic_valid,
  input  logic       dc_valid,
  input  requester_e last_grant,
  output logic       grant_valid,
  output requester_e grant_id
);

  always_comb begin
    grant_valid = ic_valid | dc_valid;
    grant_id    = REQ_ICACHE;
    if (ic_valid && dc_valid) begin
      // Only a tie consults history; a lone requester always wins.
      grant_id = other_requester(last_grant);
    end else if (dc_valid) begin
      grant_id = REQ_DCACHE;
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 request port between the icache and dcache. A winning request
// is latched and presented to L2 until fulfilled; the completion pulse and
// returned word go to the owner only. Round-robin on ties, non-preemptive.
// Ports: clk, reset (sync, active-low); ic_*/dc_* requester side
//        (address/type/valid/store word in, fetched word/fulfilled out);
//        l2_* L2 side (registered request out, fetched word/fulfilled in).
module l2_port_arbiter
  import xentry_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [XLEN-1:0]   ic_req_address,
  input  memory_operation_e ic_req_type,
  input  logic              ic_req_valid,
  input  logic [XLEN-1:0]   ic_word_to_store,
  output logic [XLEN-1:0]   ic_fetched_word,
  output logic              ic_req_fulfilled,

  input  logic [XLEN-1:0]   dc_req_address,
  input  memory_operation_e dc_req_type,
  input  logic              dc_req_valid,
  input  logic [XLEN-1:0]   dc_word_to_store,
  output logic [XLEN-1:0]   dc_fetched_word,
  output logic              dc_req_fulfilled,

  output logic [XLEN-1:0]   l2_req_address,
  output memory_operation_e l2_req_type,
  output logic              l2_req_valid,
  output logic [XLEN-1:0]   l2_word_to_store,
  input  logic [XLEN-1:0]   l2_fetched_word,
  input  logic              l2_req_fulfilled
);

  arb_state_e        state;
  requester_e        owner;
  requester_e        last_grant;
  logic [XLEN-1:0]   lat_address;
  memory_operation_e lat_type;
  logic [XLEN-1:0]   lat_word;

  logic              grant_valid;
  requester_e        grant_id;
  logic              busy;
  logic              done;

  l2_rr_picker u_picker (
    .ic_valid    (ic_req_valid),
    .dc_valid    (dc_req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      owner       <= REQ_ICACHE;
      // Pretending dcache went last lets icache win the first tie.
      last_grant  <= REQ_DCACHE;
      lat_address <= '0;
      lat_type    <= MEM_LOAD;
      lat_word    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            state      <= ARB_BUSY;
            owner      <= grant_id;
            last_grant <= grant_id;
            if (grant_id == REQ_ICACHE) begin
              lat_address <= ic_req_address;
              lat_type    <= ic_req_type;
              lat_word    <= ic_word_to_store;
            end else begin
              lat_address <= dc_req_address;
              lat_type    <= dc_req_type;
              lat_word    <= dc_word_to_store;
            end
          end
        end
        ARB_BUSY: begin
          // Always drop back to idle: the next grant is decided there,
          // which is what produces the single bubble after each completion.
          if (l2_req_fulfilled) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Reset gates the outputs combinationally so that a completion landing in
  // the reset cycle is dropped rather than pulsed to the owner.
  assign busy = reset && (state == ARB_BUSY);
  assign done = busy && l2_req_fulfilled;

  assign l2_req_valid     = busy;
  assign l2_req_address   = lat_address;
  assign l2_req_type      = lat_type;
  assign l2_word_to_store = lat_word;

  // Return data is steered to the owner only and only in the completion
  // cycle, so neither requester ever sees the other's traffic.
  assign ic_req_fulfilled = done && (owner == REQ_ICACHE);
  assign dc_req_fulfilled = done && (owner == REQ_DCACHE);
  assign ic_fetched_word  = ic_req_fulfilled ? l2_fetched_word : '0;
  assign dc_fetched_word  = dc_req_fulfilled ? l2_fetched_word : '0;

  // Protocol monitors. These are warnings: the hardware tolerates both
  // situations (stray completion ignored, abandoned request still completed).
  a_no_fulfil_when_idle : assert property (
    @(posedge clk) disable iff (!reset)
    (state == ARB_IDLE) |-> !l2_req_fulfilled
  ) else $warning("l2_req_fulfilled seen while arbiter idle; ignored");

  a_ic_holds_valid : assert property (
    @(posedge clk) disable iff (!reset)
    (state == ARB_BUSY && owner == REQ_ICACHE) |-> ic_req_valid
  ) else $warning("icache dropped request valid before fulfilment");

  a_dc_holds_valid : assert property (
    @(posedge clk) disable iff (!reset)
    (state == ARB_BUSY && owner == REQ_DCACHE) |-> dc_req_valid
  ) else $warning("dcache dropped request valid before fulfilment");

endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;
  import xentry_pkg::*;

  localparam int XLEN = 32;
  localparam int RAND_CYCLES = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [XLEN-1:0]   ic_req_address, dc_req_address;
  memory_operation_e ic_req_type, dc_req_type;
  logic              ic_req_valid, dc_req_valid;
  logic [XLEN-1:0]   ic_word_to_store, dc_word_to_store;
  logic [XLEN-1:0]   ic_fetched_word, dc_fetched_word;
  logic              ic_req_fulfilled, dc_req_fulfilled;
  logic [XLEN-1:0]   l2_req_address;
  memory_operation_e l2_req_type;
  logic              l2_req_valid;
  logic [XLEN-1:0]   l2_word_to_store;
  logic [XLEN-1:0]   l2_fetched_word;
  logic              l2_req_fulfilled;

  l2_port_arbiter #(.XLEN(XLEN)) dut (
    .clk              (clk),
    .reset            (reset),
    .ic_req_address   (ic_req_address),
    .ic_req_type      (ic_req_type),
    .ic_req_valid     (ic_req_valid),
    .ic_word_to_store (ic_word_to_store),
    .ic_fetched_word  (ic_fetched_word),
    .ic_req_fulfilled (ic_req_fulfilled),
    .dc_req_address   (dc_req_address),
    .dc_req_type      (dc_req_type),
    .dc_req_valid     (dc_req_valid),
    .dc_word_to_store (dc_word_to_store),
    .dc_fetched_word  (dc_fetched_word),
    .dc_req_fulfilled (dc_req_fulfilled),
    .l2_req_address   (l2_req_address),
    .l2_req_type      (l2_req_type),
    .l2_req_valid     (l2_req_valid),
    .l2_word_to_store (l2_word_to_store),
    .l2_fetched_word  (l2_fetched_word),
    .l2_req_fulfilled (l2_req_fulfilled)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string             name;
    logic              rst;
    logic              icv;
    logic [31:0]       ica;
    memory_operation_e ict;
    logic [31:0]       icw;
    logic              dcv;
    logic [31:0]       dca;
    memory_operation_e dct;
    logic [31:0]       dcw;
    logic              l2f;
    logic [31:0]       l2d;
    logic              e_l2v;
    logic              chk_l2;
    logic [31:0]       e_l2a;
    memory_operation_e e_l2t;
    logic [31:0]       e_l2w;
    logic              e_icf;
    logic [31:0]       e_icd;
    logic              e_dcf;
    logic [31:0]       e_dcd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic rst,
                     input logic icv, input logic [31:0] ica, input memory_operation_e ict, input logic [31:0] icw,
                     input logic dcv, input logic [31:0] dca, input memory_operation_e dct, input logic [31:0] dcw,
                     input logic l2f, input logic [31:0] l2d,
                     input logic e_l2v, input logic chk_l2, input logic [31:0] e_l2a,
                     input memory_operation_e e_l2t, input logic [31:0] e_l2w,
                     input logic e_icf, input logic [31:0] e_icd, input logic e_dcf, input logic [31:0] e_dcd);
    vec_t v;
    v.name = nm; v.rst = rst;
    v.icv = icv; v.ica = ica; v.ict = ict; v.icw = icw;
    v.dcv = dcv; v.dca = dca; v.dct = dct; v.dcw = dcw;
    v.l2f = l2f; v.l2d = l2d;
    v.e_l2v = e_l2v; v.chk_l2 = chk_l2; v.e_l2a = e_l2a; v.e_l2t = e_l2t; v.e_l2w = e_l2w;
    v.e_icf = e_icf; v.e_icd = e_icd; v.e_dcf = e_dcf; v.e_dcd = e_dcd;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst,
                       input logic icv, input logic [31:0] ica, input memory_operation_e ict, input logic [31:0] icw,
                       input logic dcv, input logic [31:0] dca, input memory_operation_e dct, input logic [31:0] dcw,
                       input logic l2f, input logic [31:0] l2d);
    reset = rst;
    ic_req_valid = icv; ic_req_address = ica; ic_req_type = ict; ic_word_to_store = icw;
    dc_req_valid = dcv; dc_req_address = dca; dc_req_type = dct; dc_word_to_store = dcw;
    l2_req_fulfilled = l2f; l2_fetched_word = l2d;
  endtask

  task automatic build_table();
    // test 1: reset held with both valid, then icache wins the first tie
    add("rst_hold0", 0, 1,'h100,MEM_LOAD,'h11, 1,'h200,MEM_LOAD,'h22, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("rst_hold1", 0, 1,'h100,MEM_LOAD,'h11, 1,'h200,MEM_LOAD,'h22, 0,0, 0,1,0,MEM_LOAD,0, 0,0,0,0);
    add("rst_hold2", 0, 1,'h100,MEM_LOAD,'h11, 1,'h200,MEM_LOAD,'h22, 0,0, 0,1,0,MEM_LOAD,0, 0,0,0,0);
    add("rst_rel",   1, 1,'h100,MEM_LOAD,'h11, 1,'h200,MEM_LOAD,'h22, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("ic_first",  1, 1,'h100,MEM_LOAD,'h11, 1,'h200,MEM_LOAD,'h22, 0,0, 1,1,'h100,MEM_LOAD,'h11, 0,0,0,0);
    add("ic_done",   1, 1,'h100,MEM_LOAD,'h11, 1,'h200,MEM_LOAD,'h22, 1,'hA5A50001, 1,1,'h100,MEM_LOAD,'h11, 1,'hA5A50001,0,0);
    add("dc_gap",    1, 0,'h100,MEM_LOAD,'h11, 1,'h200,MEM_LOAD,'h22, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("dc_done",   1, 0,'h100,MEM_LOAD,'h11, 1,'h200,MEM_LOAD,'h22, 1,'h5A5A0002, 1,1,'h200,MEM_LOAD,'h22, 0,0,1,'h5A5A0002);
    add("idle1",     1, 0,0,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    // test 2: icache load, L2 answers 4 cycles after valid rises
    add("t2_req",    1, 1,'h1040,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t2_n1",     1, 1,'h1040,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,'h11111111, 1,1,'h1040,MEM_LOAD,0, 0,0,0,0);
    add("t2_wait1",  1, 1,'h1040,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,'h11111111, 1,1,'h1040,MEM_LOAD,0, 0,0,0,0);
    add("t2_wait2",  1, 1,'h1040,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,'h11111111, 1,1,'h1040,MEM_LOAD,0, 0,0,0,0);
    add("t2_wait3",  1, 1,'h1040,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,'h11111111, 1,1,'h1040,MEM_LOAD,0, 0,0,0,0);
    add("t2_done",   1, 1,'h1040,MEM_LOAD,0, 0,0,MEM_LOAD,0, 1,'hDEADBEEF, 1,1,'h1040,MEM_LOAD,0, 1,'hDEADBEEF,0,0);
    add("t2_idle",   1, 0,'h1040,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    // test 3: grant order ic, dc, ic with idle gaps; then a tie after ic -> dc
    add("t3_rst",    0, 1,'h300,MEM_LOAD,'h33, 1,'h400,MEM_STORE,'h44, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t3_tie1",   1, 1,'h300,MEM_LOAD,'h33, 1,'h400,MEM_STORE,'h44, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t3_ic",     1, 1,'h300,MEM_LOAD,'h33, 1,'h400,MEM_STORE,'h44, 1,'h3001, 1,1,'h300,MEM_LOAD,'h33, 1,'h3001,0,0);
    add("t3_gap1",   1, 0,'h300,MEM_LOAD,'h33, 1,'h400,MEM_STORE,'h44, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t3_dc",     1, 1,'h500,MEM_LOAD,'h55, 1,'h400,MEM_STORE,'h44, 0,0, 1,1,'h400,MEM_STORE,'h44, 0,0,0,0);
    add("t3_dc_done",1, 1,'h500,MEM_LOAD,'h55, 1,'h400,MEM_STORE,'h44, 1,'h4001, 1,1,'h400,MEM_STORE,'h44, 0,0,1,'h4001);
    add("t3_gap2",   1, 1,'h500,MEM_LOAD,'h55, 0,'h400,MEM_STORE,'h44, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t3_ic2",    1, 1,'h500,MEM_LOAD,'h55, 0,'h400,MEM_STORE,'h44, 1,'h5001, 1,1,'h500,MEM_LOAD,'h55, 1,'h5001,0,0);
    add("t3_idle",   1, 0,0,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t3_tie2",   1, 1,'h600,MEM_LOAD,'h66, 1,'h700,MEM_STORE,'h77, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t3_tie_dc", 1, 1,'h600,MEM_LOAD,'h66, 1,'h700,MEM_STORE,'h77, 1,'h7001, 1,1,'h700,MEM_STORE,'h77, 0,0,1,'h7001);
    add("t3_gap3",   1, 1,'h600,MEM_LOAD,'h66, 0,'h700,MEM_STORE,'h77, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t3_ic3",    1, 1,'h600,MEM_LOAD,'h66, 0,'h700,MEM_STORE,'h77, 1,'h6001, 1,1,'h600,MEM_LOAD,'h66, 1,'h6001,0,0);
    add("t3_end",    1, 0,0,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    // test 4: dcache store, inputs change mid-transaction, latched copy holds
    add("t4_req",    1, 0,0,MEM_LOAD,0, 1,'h2000,MEM_STORE,'h12345678, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t4_busy",   1, 0,0,MEM_LOAD,0, 1,'h2000,MEM_STORE,'h12345678, 0,0, 1,1,'h2000,MEM_STORE,'h12345678, 0,0,0,0);
    add("t4_chg",    1, 0,0,MEM_LOAD,0, 1,'h9999,MEM_LOAD,'hFFFFFFFF, 0,0, 1,1,'h2000,MEM_STORE,'h12345678, 0,0,0,0);
    add("t4_done",   1, 0,0,MEM_LOAD,0, 1,'h9999,MEM_LOAD,'hFFFFFFFF, 1,'hC0DE0004, 1,1,'h2000,MEM_STORE,'h12345678, 0,0,1,'hC0DE0004);
    add("t4_idle",   1, 0,0,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    // test 5: reset lands on the completion cycle; latched fields cleared
    add("t5_req",    1, 1,'h800,MEM_LOAD,'h88, 0,0,MEM_LOAD,0, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t5_busy",   1, 1,'h800,MEM_LOAD,'h88, 0,0,MEM_LOAD,0, 0,0, 1,1,'h800,MEM_LOAD,'h88, 0,0,0,0);
    add("t5_rst_ful",0, 1,'h800,MEM_LOAD,'h88, 0,0,MEM_LOAD,0, 1,'hBAD00BAD, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t5_after",  1, 1,'h800,MEM_LOAD,'h88, 0,0,MEM_LOAD,0, 0,0, 0,1,0,MEM_LOAD,0, 0,0,0,0);
    add("t5_regrant",1, 1,'h800,MEM_LOAD,'h88, 0,0,MEM_LOAD,0, 1,'h8001, 1,1,'h800,MEM_LOAD,'h88, 1,'h8001,0,0);
    add("t5_idle",   1, 0,0,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    // test 6: stray completion while idle is ignored
    add("t6_stray",  1, 0,0,MEM_LOAD,0, 0,0,MEM_LOAD,0, 1,'h66666666, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t6_req",    1, 0,0,MEM_LOAD,0, 1,'h900,MEM_LOAD,'h99, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
    add("t6_done",   1, 0,0,MEM_LOAD,0, 1,'h900,MEM_LOAD,'h99, 1,'h9001, 1,1,'h900,MEM_LOAD,'h99, 0,0,1,'h9001);
    add("t6_idle",   1, 0,0,MEM_LOAD,0, 0,0,MEM_LOAD,0, 0,0, 0,0,0,MEM_LOAD,0, 0,0,0,0);
  endtask

  // ---------------- transaction-level reference model ----------------
  // One in-service transaction at most; on a tie the requester that was not
  // served last wins. Requester 0 = icache, 1 = dcache.
  typedef struct {
    int                who;
    logic [31:0]       a;
    memory_operation_e t;
    logic [31:0]       w;
  } txn_t;

  txn_t cur_q[$];
  int   served_last;

  logic              r_v[2];
  logic [31:0]       r_a[2];
  memory_operation_e r_t[2];
  logic [31:0]       r_w[2];
  logic              r_drop[2];

  task automatic run_random();
    logic        rst, l2f;
    logic [31:0] l2d;
    logic        e_f[2];
    logic [31:0] e_d[2];
    logic        e_l2v;
    txn_t        tx;
    int          winner;
    for (int r = 0; r < 2; r++) begin
      r_v[r] = 0; r_a[r] = 0; r_t[r] = MEM_LOAD; r_w[r] = 0; r_drop[r] = 0;
    end
    cur_q.delete();
    served_last = 1;
    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      rst = (cyc == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      for (int r = 0; r < 2; r++) begin
        if (r_drop[r]) begin
          r_v[r] = 0;
          r_drop[r] = 0;
        end else if (!r_v[r] && $urandom_range(0, 2) == 0) begin
          r_v[r] = 1;
          r_a[r] = $urandom;
          r_t[r] = ($urandom_range(0, 1) == 1) ? MEM_STORE : MEM_LOAD;
          r_w[r] = $urandom;
        end
      end
      l2f = (cur_q.size() != 0) && ($urandom_range(0, 2) == 0);
      l2d = $urandom;
      drive(rst, r_v[0], r_a[0], r_t[0], r_w[0], r_v[1], r_a[1], r_t[1], r_w[1], l2f, l2d);

      e_l2v = rst && (cur_q.size() != 0);
      for (int r = 0; r < 2; r++) begin
        e_f[r] = e_l2v && l2f && (cur_q[0].who == r);
        e_d[r] = e_f[r] ? l2d : 32'h0;
      end

      @(negedge clk);
      chk("rnd_l2_valid", 32'(l2_req_valid), 32'(e_l2v));
      if (e_l2v) begin
        chk("rnd_l2_addr", l2_req_address, cur_q[0].a);
        chk("rnd_l2_type", 32'(l2_req_type), 32'(cur_q[0].t));
        chk("rnd_l2_word", l2_word_to_store, cur_q[0].w);
      end
      chk("rnd_ic_ful", 32'(ic_req_fulfilled), 32'(e_f[0]));
      chk("rnd_ic_word", ic_fetched_word, e_d[0]);
      chk("rnd_dc_ful", 32'(dc_req_fulfilled), 32'(e_f[1]));
      chk("rnd_dc_word", dc_fetched_word, e_d[1]);

      // advance the model across the clock edge
      if (!rst) begin
        cur_q.delete();
        served_last = 1;
      end else if (cur_q.size() != 0) begin
        if (l2f) begin
          r_drop[cur_q[0].who] = 1;
          void'(cur_q.pop_front());
        end
      end else begin
        winner = -1;
        if (r_v[0] && r_v[1]) winner = 1 - served_last;
        else if (r_v[0])      winner = 0;
        else if (r_v[1])      winner = 1;
        if (winner >= 0) begin
          tx.who = winner; tx.a = r_a[winner]; tx.t = r_t[winner]; tx.w = r_w[winner];
          cur_q.push_back(tx);
          served_last = winner;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    build_table();
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].icv, tbl[i].ica, tbl[i].ict, tbl[i].icw,
            tbl[i].dcv, tbl[i].dca, tbl[i].dct, tbl[i].dcw, tbl[i].l2f, tbl[i].l2d);
      @(negedge clk);
      chk({tbl[i].name, ".l2_valid"}, 32'(l2_req_valid), 32'(tbl[i].e_l2v));
      if (tbl[i].chk_l2) begin
        chk({tbl[i].name, ".l2_addr"}, l2_req_address, tbl[i].e_l2a);
        chk({tbl[i].name, ".l2_type"}, 32'(l2_req_type), 32'(tbl[i].e_l2t));
        chk({tbl[i].name, ".l2_word"}, l2_word_to_store, tbl[i].e_l2w);
      end
      chk({tbl[i].name, ".ic_ful"}, 32'(ic_req_fulfilled), 32'(tbl[i].e_icf));
      chk({tbl[i].name, ".ic_word"}, ic_fetched_word, tbl[i].e_icd);
      chk({tbl[i].name, ".dc_ful"}, 32'(dc_req_fulfilled), 32'(tbl[i].e_dcf));
      chk({tbl[i].name, ".dc_word"}, dc_fetched_word, tbl[i].e_dcd);
      @(posedge clk);
      #1;
    end

    run_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
Two-requester arbiter sharing a single L2 request port between the instruction cache and the data cache miss/writeback interfaces.
- Captures the winning request into holding registers and drives it to L2 until fulfilled.
- Routes the fulfilment and fetched word back to the owner only.
- Round-robin fairness with non-preemptive grants.
- Sits between icache/dcache L2-side ports and the L2 (or memory model).

Parameters:
XLEN, 32, address/data width in bits

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-low reset
ic_req_address  input  XLEN  icache L2 request address
ic_req_type  input  memory_operation_e  icache request type (load/store)
ic_req_valid  input  1  icache request valid, held until ic_req_fulfilled
ic_word_to_store  input  XLEN  icache store data
ic_fetched_word  output  XLEN  data returned to icache
ic_req_fulfilled  output  1  one-cycle completion pulse to icache
dc_req_address  input  XLEN  dcache request address
dc_req_type  input  memory_operation_e  dcache request type
dc_req_valid  input  1  dcache request valid, held until dc_req_fulfilled
dc_word_to_store  input  XLEN  dcache store data
dc_fetched_word  output  XLEN  data returned to dcache
dc_req_fulfilled  output  1  one-cycle completion pulse to dcache
l2_req_address  output  XLEN  registered request address to L2
l2_req_type  output  memory_operation_e  registered request type to L2
l2_req_valid  output  1  request valid to L2
l2_word_to_store  output  XLEN  registered store data to L2
l2_fetched_word  input  XLEN  L2 return data
l2_req_fulfilled  input  1  L2 completion, valid only while l2_req_valid=1

Behaviour:
- Interface clocking: one clock, clk; reset is synchronous and active-low (reset=0 resets).
- States: ARB_IDLE, ARB_BUSY. Registers: state, owner (requester_e), last_grant, and latched address/type/store word.
- Reset (any cycle, including mid-transaction):
  - state=ARB_IDLE, last_grant=REQ_DCACHE (icache wins the first tie), owner=REQ_ICACHE.
  - Latched fields reset to 0 and MEM_LOAD.
  - Outputs: l2_req_valid=0, *_req_fulfilled=0, *_fetched_word=0.
  - An in-flight L2 response is dropped; L2 must also be reset.
- ARB_IDLE:
  - l2_req_valid=0.
  - Only ic valid -> grant ic. Only dc valid -> grant dc.
  - Both valid -> grant the requester that is not last_grant.
  - On grant: latch that requester's address/type/store word, set owner=winner and last_grant=winner, then go to ARB_BUSY next cycle.
  - Neither valid -> stay.
- ARB_BUSY:
  - l2_req_valid=1; l2_* driven from latched registers only (stable for the whole transaction regardless of requester inputs).
  - On l2_req_fulfilled=1: combinationally pulse owner's *_req_fulfilled in the same cycle, drive owner's *_fetched_word=l2_fetched_word, go to ARB_IDLE.
- Latency: request valid at cycle N (idle arbiter) -> l2_req_valid at N+1. Minimum owner turnaround = L2 latency + 1. One idle bubble always follows each completion.
- Non-owner outputs: *_req_fulfilled=0 always; *_fetched_word=0 (no data leakage).
- Non-preemptive: a newly asserted valid from the other requester during ARB_BUSY waits. It is granted in the IDLE cycle after completion if still valid.
- Requester protocol: valid held until fulfilled and deasserted in the following cycle. If the owner drops valid mid-BUSY, the arbiter still completes the L2 transaction and pulses fulfilled (protocol violation; flagged by assertion only).
- l2_req_fulfilled while ARB_IDLE: ignored, no output pulse. An assertion flags it.
- Back-to-back same requester (other idle): granted again, since round-robin only applies to ties.

Decomposition:
- xentry_pkg additions: arb_state_e {ARB_IDLE, ARB_BUSY}, requester_e {REQ_ICACHE, REQ_DCACHE}. Reuse the existing memory_operation_e.
- Sub-module l2_rr_picker: combinational 2-way round-robin select.
  - Inputs: ic_valid, dc_valid, last_grant.
  - Outputs: grant_valid, grant_id.
- Top-level contains the FSM, latches and return demux.

Test Plan:
1. Reset held low with both valids high for 3 cycles -> l2_req_valid=0 and both fulfilled=0 throughout; after release, icache granted first.
2. Only ic valid, address 0x0000_1040, MEM_LOAD; L2 fulfils 4 cycles after l2_req_valid rises with 0xDEAD_BEEF -> l2_req_address=0x0000_1040 from N+1; ic_fetched_word=0xDEAD_BEEF and ic_req_fulfilled high for exactly one cycle; dc outputs stay 0.
3. Both valid simultaneously, three consecutive transactions -> grant order ic, dc, ic; each with a one-cycle idle gap.
4. dc MEM_STORE, address 0x0000_2000, data 0x1234_5678; change dc_word_to_store to 0xFFFF_FFFF mid-BUSY -> l2_word_to_store stays 0x1234_5678 until fulfilled.
5. Reset asserted during ARB_BUSY with L2 fulfilling the same cycle -> no fulfilled pulse; next cycle state IDLE, l2_req_valid=0.
6. l2_req_fulfilled pulsed while idle -> no requester fulfilled pulse; assertion fires.
